// File: rtl/huc_pkg.sv
// Shared types and constants for the HuCard memory controller.
package huc_pkg;

    localparam int ADDR_W_DEF = 23;
    localparam logic [7:0] BUS_IDLE_DAT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_HOLD,
        WR_ARM,
        WR_REQ
    } huc_state_t;

endpackage

// File: rtl/huc_strb_sync.sv
// N-stage synchroniser for an active-low bus strobe, with edge pulses taken
// from the settled output and one extra history flop.
module huc_strb_sync #(
    parameter int STG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    output logic q,
    output logic fall,
    output logic rise
);

    logic [STG-1:0] sr;
    logic           q_d;

    // Strobes idle high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '1;
            q_d <= 1'b1;
        end else begin
            sr  <= {sr[STG-2:0], d_raw};
            q_d <= sr[STG-1];
        end
    end

    assign q    = sr[STG-1];
    assign fall = q_d & ~q;
    assign rise = ~q_d & q;

endmodule

// File: rtl/huc_mem_ctrl.sv
// Cartridge-bus to PSRAM request bridge: synchronises the raw strobes and
// turns each access into one request/ack transaction on the memory port.
//
// state   | meaning
// IDLE    | no access in flight, watching for strobe falls
// RD_REQ  | read request outstanding, waiting for mem_ack
// RD_HOLD | read data driven on the cartridge bus until the strobe ends
// WR_ARM  | write accepted, waiting for we_n to rise so the data is settled
// WR_REQ  | write request outstanding, waiting for mem_ack
module huc_mem_ctrl
    import huc_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int SYNC_STG = 2,
    parameter int TMO_CYC  = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_n,
    input  logic              cpu_oe_n,
    input  logic              cpu_we_n,
    input  logic [7:0]        cpu_dat_i,
    input  logic [ADDR_W-1:0] map_addr,
    input  logic              map_rom_ce,
    input  logic              map_ram_ce,
    input  logic              map_ram_we,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_di,
    input  logic [7:0]        mem_do,
    input  logic              mem_ack,
    output logic [7:0]        cpu_dat_o,
    output logic              cpu_dat_oe,
    output logic              busy,
    output logic              err_late
);

    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic ce_s, ce_fall, ce_rise;
    logic oe_s, oe_fall, oe_rise;
    logic we_s, we_fall, we_rise;
    logic unused_edges;

    huc_strb_sync #(.STG(SYNC_STG)) u_sync_ce (
        .clk(clk), .rst(rst), .d_raw(cpu_ce_n), .q(ce_s), .fall(ce_fall), .rise(ce_rise)
    );
    huc_strb_sync #(.STG(SYNC_STG)) u_sync_oe (
        .clk(clk), .rst(rst), .d_raw(cpu_oe_n), .q(oe_s), .fall(oe_fall), .rise(oe_rise)
    );
    huc_strb_sync #(.STG(SYNC_STG)) u_sync_we (
        .clk(clk), .rst(rst), .d_raw(cpu_we_n), .q(we_s), .fall(we_fall), .rise(we_rise)
    );

    assign unused_edges = ^{ce_fall, ce_rise, oe_rise, we_s};

    // Write data follows the same pipeline depth as we_n so both settle together.
    logic [7:0] dat_sr [SYNC_STG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STG; i++) dat_sr[i] <= 8'h00;
        end else begin
            dat_sr[0] <= cpu_dat_i;
            for (int i = 1; i < SYNC_STG; i++) dat_sr[i] <= dat_sr[i-1];
        end
    end

    huc_state_t        state, state_nx;
    logic              req_nx, we_nx, oe_nx, err_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        di_nx, dat_nx;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_di     <= 8'h00;
            cpu_dat_o  <= BUS_IDLE_DAT;
            cpu_dat_oe <= 1'b0;
            err_late   <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_nx;
            mem_req    <= req_nx;
            mem_we     <= we_nx;
            mem_addr   <= addr_nx;
            mem_di     <= di_nx;
            cpu_dat_o  <= dat_nx;
            cpu_dat_oe <= oe_nx;
            err_late   <= err_nx;
            tmo_cnt    <= tmo_nx;
        end
    end

    always_comb begin
        state_nx = state;
        req_nx   = mem_req;
        we_nx    = mem_we;
        addr_nx  = mem_addr;
        di_nx    = mem_di;
        dat_nx   = cpu_dat_o;
        oe_nx    = cpu_dat_oe;
        err_nx   = err_late;
        tmo_nx   = tmo_cnt;

        // Down-counter reaching terminal count flags a slow memory but keeps waiting.
        if (mem_req) begin
            if (tmo_cnt != '0) tmo_nx = tmo_cnt - TMO_W'(1);
            else               err_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                oe_nx = 1'b0;
                if (!ce_s) begin
                    if (we_fall) begin
                        if (map_ram_ce && map_ram_we) begin
                            addr_nx  = map_addr;
                            state_nx = WR_ARM;
                        end
                    end else if (oe_fall) begin
                        if (map_rom_ce || map_ram_ce) begin
                            addr_nx  = map_addr;
                            we_nx    = 1'b0;
                            req_nx   = 1'b1;
                            tmo_nx   = TMO_W'(TMO_CYC);
                            state_nx = RD_REQ;
                        end else begin
                            dat_nx = BUS_IDLE_DAT;
                        end
                    end
                end
            end
            RD_REQ: begin
                if (mem_ack) begin
                    req_nx = 1'b0;
                    dat_nx = mem_do;
                    if (!oe_s) begin
                        oe_nx    = 1'b1;
                        state_nx = RD_HOLD;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            RD_HOLD: begin
                if (oe_s || ce_s) begin
                    oe_nx    = 1'b0;
                    state_nx = IDLE;
                end
            end
            WR_ARM: begin
                if (we_rise) begin
                    di_nx    = dat_sr[SYNC_STG-1];
                    we_nx    = 1'b1;
                    req_nx   = 1'b1;
                    tmo_nx   = TMO_W'(TMO_CYC);
                    state_nx = WR_REQ;
                end
            end
            WR_REQ: begin
                if (mem_ack) begin
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_huc_mem_ctrl.sv
// Bench for huc_mem_ctrl: directed sequences, a vector table and randomized
// accesses against a transaction-level model, with an auto-acking memory.
module tb_huc_mem_ctrl;

    localparam int ADDR_W   = 23;
    localparam int SYNC_STG = 2;
    localparam int TMO_CYC  = 48;

    logic              clk, rst;
    logic              cpu_ce_n, cpu_oe_n, cpu_we_n;
    logic [7:0]        cpu_dat_i;
    logic [ADDR_W-1:0] map_addr;
    logic              map_rom_ce, map_ram_ce, map_ram_we;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_di, mem_do;
    logic              mem_ack;
    logic [7:0]        cpu_dat_o;
    logic              cpu_dat_oe, busy, err_late;

    huc_mem_ctrl #(.ADDR_W(ADDR_W), .SYNC_STG(SYNC_STG), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst(rst),
        .cpu_ce_n(cpu_ce_n), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n), .cpu_dat_i(cpu_dat_i),
        .map_addr(map_addr), .map_rom_ce(map_rom_ce), .map_ram_ce(map_ram_ce), .map_ram_we(map_ram_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
        .mem_do(mem_do), .mem_ack(mem_ack),
        .cpu_dat_o(cpu_dat_o), .cpu_dat_oe(cpu_dat_oe), .busy(busy), .err_late(err_late)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic err_exp = 1'b0;
    logic ack_en;
    int   ack_dly;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: acks ack_dly falling edges after seeing mem_req, one-cycle pulse.
    initial begin
        int wait_cnt;
        mem_ack  = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                if (!rst) check("req_drop_after_ack", mem_req, 1'b0);
            end else if (mem_req) begin
                wait_cnt++;
                if (ack_en && wait_cnt >= ack_dly) mem_ack = 1'b1;
            end else begin
                wait_cnt = 0;
            end
        end
    end

    typedef struct {
        logic              is_wr, rom, ram, rwe;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wd, rd;
        int                len, dly;
        logic              exp_req, exp_oe;
    } vec_t;

    function automatic vec_t mk(input logic is_wr, rom, ram, rwe, input logic [ADDR_W-1:0] addr,
                                input logic [7:0] wd, rd, input int len, dly,
                                input logic exp_req, exp_oe);
        vec_t v;
        v.is_wr = is_wr; v.rom = rom; v.ram = ram; v.rwe = rwe; v.addr = addr;
        v.wd = wd; v.rd = rd; v.len = len; v.dly = dly; v.exp_req = exp_req; v.exp_oe = exp_oe;
        return v;
    endfunction

    // Reference rules: a read is served when mapped; a write only to writable RAM;
    // read data reaches the bus only if the strobe is still held when it arrives
    // (strobe held longer than the ack wait, boundary avoided by the stimulus).
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_req = v.is_wr ? (v.ram & v.rwe) : (v.rom | v.ram);
        r.exp_oe  = !v.is_wr && r.exp_req && (v.len > v.dly);
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_access(input vec_t v);
        int   cyc, first_req;
        logic seen_req, seen_oe, seen_busy, oe_bad, stab_bad;
        logic req_we;
        logic [ADDR_W-1:0] req_addr;
        logic [7:0] req_di;
        map_addr = v.addr; map_rom_ce = v.rom; map_ram_ce = v.ram; map_ram_we = v.rwe;
        cpu_dat_i = v.wd; mem_do = v.rd; ack_dly = v.dly; ack_en = 1'b1;
        cpu_ce_n = 1'b0;
        if (v.is_wr) cpu_we_n = 1'b0; else cpu_oe_n = 1'b0;
        cyc = 0; first_req = -1;
        seen_req = 0; seen_oe = 0; seen_busy = 0; oe_bad = 0; stab_bad = 0;
        req_we = 0; req_addr = '0; req_di = '0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (busy) seen_busy = 1;
            if (mem_req) begin
                if (!seen_req) begin
                    seen_req = 1; first_req = cyc;
                    req_we = mem_we; req_addr = mem_addr; req_di = mem_di;
                end else if (mem_we !== req_we || mem_addr !== req_addr || (req_we && mem_di !== req_di)) begin
                    stab_bad = 1;
                end
            end
            if (cpu_dat_oe) begin
                seen_oe = 1;
                if (cpu_dat_o !== v.rd) oe_bad = 1;
            end
            if (cyc == v.len) begin cpu_oe_n = 1'b1; cpu_we_n = 1'b1; end
            if (cyc > v.len + 3 && !busy) break;
            if (cyc > 300) break;
        end
        if (v.exp_req && !v.is_wr && !v.exp_oe) err_exp = 1'b1;
        check("txn_req_issued", seen_req, v.exp_req);
        check("txn_busy_seen", seen_busy, v.exp_req);
        check("txn_dat_oe_seen", seen_oe, v.exp_oe);
        if (seen_req) begin
            check("txn_addr", req_addr, v.addr);
            check("txn_we", req_we, v.is_wr);
            check("txn_stable", stab_bad, 1'b0);
            if (v.is_wr) begin
                check("txn_wdata", req_di, v.wd);
                check("txn_wr_after_rise", first_req > v.len, 1'b1);
            end
        end
        if (seen_oe) check("txn_rdata", oe_bad, 1'b0);
        check("txn_busy_end", busy, 1'b0);
        check("txn_err_late", err_late, err_exp);
        cpu_ce_n = 1'b1;
        idle(3);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        err_exp = 1'b0;
        idle(2);
    endtask

    vec_t tbl [7];

    initial begin
        vec_t v;
        int   c;
        logic seen;

        tbl[0] = mk(1, 0, 1, 1, 23'h400010, 8'h3C, 8'h00, 10, 3, 1, 0); // RAM write
        tbl[1] = mk(1, 0, 1, 0, 23'h400010, 8'h3C, 8'h00, 10, 3, 0, 0); // protected RAM
        tbl[2] = mk(1, 1, 0, 1, 23'h000200, 8'h99, 8'h00, 10, 3, 0, 0); // write to ROM
        tbl[3] = mk(0, 0, 0, 0, 23'h7FFFFF, 8'h00, 8'h12, 10, 3, 0, 0); // unmapped read
        tbl[4] = mk(0, 0, 1, 0, 23'h400020, 8'h00, 8'h5E, 10, 2, 1, 1); // RAM read
        tbl[5] = mk(0, 1, 0, 0, 23'h001000, 8'h00, 8'hE1,  2, 8, 1, 0); // late release
        tbl[6] = mk(0, 1, 0, 0, 23'h001001, 8'h00, 8'h77, 12, 3, 1, 1); // good read, err stays

        rst = 1'b1;
        cpu_ce_n = 1'b1; cpu_oe_n = 1'b1; cpu_we_n = 1'b1; cpu_dat_i = 8'h00;
        map_addr = '0; map_rom_ce = 0; map_ram_ce = 0; map_ram_we = 0;
        mem_do = 8'h00; ack_en = 1'b1; ack_dly = 3;
        idle(3);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_di", mem_di, 32'h0);
        check("rst_cpu_dat_o", cpu_dat_o, 8'hFF);
        check("rst_cpu_dat_oe", cpu_dat_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err_late", err_late, 1'b0);
        rst = 1'b0;
        idle(2);

        // ROM read, cycle-exact: request on the 3rd edge, ack 4 cycles later.
        map_addr = 23'h012345; map_rom_ce = 1; map_ram_ce = 0; map_ram_we = 0;
        mem_do = 8'hA5; ack_dly = 4;
        cpu_ce_n = 1'b0; cpu_oe_n = 1'b0;
        for (c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 2) check("rom_req_c2", mem_req, 1'b0);
            if (c == 3) begin
                check("rom_req_c3", mem_req, 1'b1);
                check("rom_addr", mem_addr, 23'h012345);
                check("rom_we", mem_we, 1'b0);
                check("rom_busy", busy, 1'b1);
            end
            if (c == 6) check("rom_oe_before_ack", cpu_dat_oe, 1'b0);
            if (c == 7) begin
                check("rom_oe_after_ack", cpu_dat_oe, 1'b1);
                check("rom_dat", cpu_dat_o, 8'hA5);
                check("rom_req_dropped", mem_req, 1'b0);
            end
            if (c == 12) cpu_oe_n = 1'b1;
            if (c == 14) check("rom_oe_held", cpu_dat_oe, 1'b1);
            if (c == 15) check("rom_oe_released", cpu_dat_oe, 1'b0);
        end
        check("rom_busy_end", busy, 1'b0);
        cpu_ce_n = 1'b1;
        idle(3);

        for (int i = 0; i < 7; i++) run_access(tbl[i]);

        // Asynchronous reset while a read is outstanding.
        map_addr = 23'h400123; map_rom_ce = 0; map_ram_ce = 1;
        mem_do = 8'h11; ack_dly = 20;
        cpu_ce_n = 1'b0; cpu_oe_n = 1'b0;
        idle(5);
        check("mid_req_before_rst", mem_req, 1'b1);
        check("mid_busy_before_rst", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_mem_req", mem_req, 1'b0);
        check("mid_rst_dat_oe", cpu_dat_oe, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_dat_o", cpu_dat_o, 8'hFF);
        check("mid_rst_err", err_late, 1'b0);
        @(negedge clk);
        rst = 1'b0; err_exp = 1'b0;
        cpu_oe_n = 1'b1; cpu_ce_n = 1'b1;
        idle(4);
        run_access(mk(0, 1, 0, 0, 23'h000321, 8'h00, 8'h6B, 10, 3, 1, 1));

        // Randomized accesses against the model.
        for (int i = 0; i < 30; i++) begin
            v.is_wr = 1'($urandom_range(0, 1));
            v.rom   = 1'($urandom_range(0, 1));
            v.ram   = 1'($urandom_range(0, 1));
            v.rwe   = ($urandom_range(0, 3) != 0);
            v.addr  = ADDR_W'($urandom);
            v.wd    = 8'($urandom);
            v.rd    = 8'($urandom);
            v.dly   = $urandom_range(2, 8);
            if (v.is_wr)                     v.len = $urandom_range(2, 10);
            else if ($urandom_range(0, 3) == 0) v.len = $urandom_range(1, v.dly - 1);
            else                             v.len = v.dly + 2 + $urandom_range(0, 5);
            run_access(model(v));
        end

        // Timeout: no ack for well past TMO_CYC, then a normal completion.
        do_reset();
        map_addr = 23'h0ABCDE; map_rom_ce = 1; map_ram_ce = 0;
        mem_do = 8'hC3; ack_en = 1'b0; ack_dly = 1;
        cpu_ce_n = 1'b0; cpu_oe_n = 1'b0;
        c = 0;
        while (!mem_req && c < 10) begin @(negedge clk); c++; end
        check("tmo_req_up", mem_req, 1'b1);
        idle(TMO_CYC - 4);
        check("tmo_err_early", err_late, 1'b0);
        idle(9);
        check("tmo_err_set", err_late, 1'b1);
        check("tmo_req_held", mem_req, 1'b1);
        ack_en = 1'b1;
        seen = 1'b0;
        for (c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (cpu_dat_oe) seen = 1'b1;
        end
        check("tmo_dat_oe", seen, 1'b1);
        check("tmo_dat", cpu_dat_o, 8'hC3);
        cpu_oe_n = 1'b1;
        for (c = 0; c < 10 && busy; c++) @(negedge clk);
        check("tmo_busy_end", busy, 1'b0);
        check("tmo_err_sticky", err_late, 1'b1);
        cpu_ce_n = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
